// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage.
//   MEM_RD / MEM_WR / MEM_BYTE : bit positions inside memctrl
//   NUM_LANES / LANE_W         : byte-lane geometry of the 32-bit data bus
//   mau_state_e                : memory-access controller state
package mips_pkg;
  localparam int MEM_RD    = 0;
  localparam int MEM_WR    = 1;
  localparam int MEM_BYTE  = 2;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mau_state_e;
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory bus (purely combinational).
//   byte_acc, addr_lo, st_data -> be, wdata   : store-side enables / replicated data
//   ld_byte, ld_lane, rdata    -> ld_data     : load-side lane extract + sign extend
module mem_lane_align
  import mips_pkg::*;
(
  input  logic                          byte_acc,
  input  logic [1:0]                    addr_lo,
  input  logic [NUM_LANES*LANE_W-1:0]   st_data,
  output logic [NUM_LANES-1:0]          be,
  output logic [NUM_LANES*LANE_W-1:0]   wdata,
  input  logic                          ld_byte,
  input  logic [1:0]                    ld_lane,
  input  logic [NUM_LANES*LANE_W-1:0]   rdata,
  output logic [NUM_LANES*LANE_W-1:0]   ld_data
);
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_lanes;
  logic [LANE_W-1:0]                sel_lane;

  assign rd_lanes = rdata;
  assign sel_lane = rd_lanes[ld_lane];

  always_comb begin
    be      = byte_acc ? (NUM_LANES'(1) << addr_lo) : '1;
    // Byte stores drive the byte on every lane; be picks the one that lands.
    wdata   = byte_acc ? {NUM_LANES{st_data[LANE_W-1:0]}} : st_data;
    ld_data = ld_byte ? {{(NUM_LANES*LANE_W-LANE_W){sel_lane[LANE_W-1]}}, sel_lane} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// MIPS memory-stage controller. Consumes EX/MEM, runs load/store on a req/ack
// data bus, stalls the pipeline while a transaction is outstanding and
// registers result/rd toward MEM/WB.
//   d1_in/d2_in/rd_in/memctrl_in : address, store data, dest reg, control
//   result_out/rd_out/access_err : registered stage outputs
//   stall                        : combinational pipeline hold
//   mem_*                        : data-memory bus
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] d1_in,
  input  logic [31:0] d2_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  memctrl_in,
  output logic [31:0] result_out,
  output logic [4:0]  rd_out,
  output logic        stall,
  output logic        access_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  mau_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d, byte_q, byte_d, err_q, err_d;
  logic [1:0]        lane_q, lane_d;
  logic [4:0]        rdl_q, rdl_d, rd_q, rd_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              stall_c;

  logic        rd_en, wr_en, byte_acc, is_acc, illegal, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ld_data;

  assign rd_en    = memctrl_in[MEM_RD];
  assign wr_en    = memctrl_in[MEM_WR];
  assign byte_acc = memctrl_in[MEM_BYTE];
  assign is_acc   = rd_en | wr_en;
  assign illegal  = (rd_en & wr_en) | (~byte_acc & (d1_in[1:0] != 2'b00));
  // tcnt_q counts completed WAIT cycles, so the final WAIT cycle sees T-1.
  assign timeout  = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

  mem_lane_align u_align (
    .byte_acc (byte_acc),
    .addr_lo  (d1_in[1:0]),
    .st_data  (d2_in),
    .be       (be_new),
    .wdata    (wdata_new),
    .ld_byte  (byte_q),
    .ld_lane  (lane_q),
    .rdata    (mem_rdata),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    byte_d   = byte_q;
    lane_d   = lane_q;
    rdl_d    = rdl_q;
    tcnt_d   = tcnt_q;
    result_d = result_q;
    rd_d     = rd_q;
    err_d    = 1'b0;
    stall_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!is_acc) begin
          result_d = d1_in;
          rd_d     = rd_in;
        end else if (illegal) begin
          result_d = '0;
          rd_d     = '0;
          err_d    = 1'b1;
        end else begin
          stall_c = 1'b1;
          addr_d  = {d1_in[31:2], 2'b00};
          wdata_d = wdata_new;
          be_d    = be_new;
          we_d    = wr_en;
          rdl_d   = rd_in;
          byte_d  = byte_acc;
          lane_d  = d1_in[1:0];
          tcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Ack beats timeout when both land in the last WAIT cycle.
        if (mem_ack) begin
          state_d  = IDLE;
          result_d = we_q ? 32'd0 : ld_data;
          rd_d     = we_q ? 5'd0  : rdl_q;
        end else if (timeout) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          result_d = '0;
          rd_d     = '0;
        end else begin
          stall_c = 1'b1;
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      lane_q   <= '0;
      rdl_q    <= '0;
      tcnt_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      lane_q   <= lane_d;
      rdl_q    <= rdl_d;
      tcnt_q   <= tcnt_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  // Held reset must not stall even if a legal access sits on the inputs.
  assign stall      = reset & stall_c;
  assign mem_req    = (state_q == WAIT);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign result_out = result_q;
  assign rd_out     = rd_q;
  assign access_err = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] d1_in, d2_in, mem_rdata;
  logic [4:0]  rd_in;
  logic [2:0]  memctrl_in;
  logic [31:0] result_out, mem_addr, mem_wdata;
  logic [4:0]  rd_out;
  logic        stall, access_err, mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .TCNT_W(3)) dut (
    .clock(clock), .reset(reset), .d1_in(d1_in), .d2_in(d2_in), .rd_in(rd_in),
    .memctrl_in(memctrl_in), .result_out(result_out), .rd_out(rd_out),
    .stall(stall), .access_err(access_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Runs one instruction from IDLE to completion. Called just after a negedge.
  // ack_n = WAIT cycle in which the responder acks (>T means never in time).
  task automatic run_instr(input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                           input logic [2:0] mc, input int ack_n, input logic [31:0] rdata);
    logic        r, w, b, acc, illeg, legal, tmo, done;
    logic [1:0]  lane;
    logic [7:0]  bytev;
    logic [31:0] e_res, e_addr, e_wdata;
    logic [4:0]  e_rd;
    logic [3:0]  e_be;
    int          e_wait, waits, stalls, cyc;
    r = mc[0]; w = mc[1]; b = mc[2];
    acc   = r | w;
    illeg = acc && ((r && w) || (!b && d1[1:0] != 2'b00));
    legal = acc && !illeg;
    tmo   = legal && (ack_n > T);
    e_wait = legal ? ((ack_n < T) ? ack_n : T) : 0;
    lane  = d1[1:0];
    bytev = 8'((rdata >> (8 * lane)) & 32'hFF);
    e_addr  = d1 & ~32'h3;
    e_be    = b ? 4'(1 << lane) : 4'hF;
    e_wdata = b ? (32'(d2[7:0]) * 32'h0101_0101) : d2;
    if (!acc)                  begin e_res = d1; e_rd = rd; end
    else if (illeg || tmo || w) begin e_res = 0; e_rd = 0; end
    else begin
      e_rd  = rd;
      e_res = b ? (bytev[7] ? (32'hFFFF_FF00 | 32'(bytev)) : 32'(bytev)) : rdata;
    end

    d1_in = d1; d2_in = d2; rd_in = rd; memctrl_in = mc;
    waits = 0; stalls = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      mem_ack = 1'b0;
      #1;
      if (cyc == 0) chk("req_in_idle", 32'(mem_req), 0);
      if (mem_req) begin
        waits++;
        if (waits == 1) begin
          chk("addr", mem_addr, e_addr);
          chk("be", 32'(mem_be), 32'(e_be));
          chk("we", 32'(mem_we), 32'(w));
          if (w) chk("wdata", mem_wdata, e_wdata);
        end
        if (waits == ack_n) begin mem_ack = 1'b1; mem_rdata = rdata; end
      end else begin
        // junk ack outside WAIT must be ignored
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      #1;
      if (stall) stalls++; else done = 1'b1;
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end
    mem_ack = 1'b0;
    chk("completes", 32'(done), 1);
    chk("stall_cycles", 32'(stalls), 32'(e_wait));
    chk("wait_cycles", 32'(waits), 32'(e_wait));
    chk("result", result_out, e_res);
    chk("rd_out", 32'(rd_out), 32'(e_rd));
    chk("access_err", 32'(access_err), 32'(illeg || tmo));
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    d1_in = '0; d2_in = '0; rd_in = '0; memctrl_in = 3'b000;
    repeat (3) @(negedge clock);
    chk("rst_result", result_out, 0);
    chk("rst_rd", 32'(rd_out), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_err", 32'(access_err), 0);
    chk("rst_addr", mem_addr, 0);
    memctrl_in = 3'b001; d1_in = 32'h100; #1;
    chk("rst_stall", 32'(stall), 0);
    memctrl_in = 3'b000;
    @(negedge clock);
    reset = 1'b1;

    // directed cases
    run_instr(32'h1234, 32'h0, 5'd5, 3'b000, 1, 0);
    run_instr(32'h100, 32'h0, 5'd7, 3'b001, 3, 32'hDEADBEEF);
    run_instr(32'h203, 32'hAB, 5'd9, 3'b110, 1, 0);
    run_instr(32'h203, 32'h0, 5'd9, 3'b101, 2, 32'h8000_0000);
    run_instr(32'h102, 32'h0, 5'd3, 3'b001, 1, 0);
    run_instr(32'h100, 32'h0, 5'd3, 3'b011, 1, 0);
    run_instr(32'h40, 32'h0, 5'd4, 3'b001, 99, 0);
    run_instr(32'h40, 32'h0, 5'd4, 3'b001, T, 32'h1357_9BDF);
    run_instr(32'h44, 32'h5555, 5'd6, 3'b010, T + 1, 0);

    // reset in the 2nd WAIT cycle
    d1_in = 32'h100; rd_in = 5'd8; memctrl_in = 3'b001;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("pre_rst_req", 32'(mem_req), 1);
    chk("pre_rst_stall", 32'(stall), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_result", result_out, 0);
    chk("mid_rst_rd", 32'(rd_out), 0);
    chk("mid_rst_err", 32'(access_err), 0);
    memctrl_in = 3'b000;
    @(negedge clock);
    reset = 1'b1;
    run_instr(32'h100, 32'h0, 5'd8, 3'b001, 2, 32'hCAFE_F00D);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      run_instr($urandom, $urandom, 5'($urandom), 3'($urandom),
                int'($urandom_range(1, T + 2)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller for the MIPS pipeline: the consumer of the EX/MEM pipeline register. It decodes `memctrl`, performs load/store transactions on the data-memory bus with a req/ack handshake, and holds the pipeline with `stall` while a transaction is outstanding. It also registers the stage result and destination register toward MEM/WB. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: number of WAIT cycles without `mem_ack` before the access is aborted. Legal range is ≥1.
- `TCNT_W`, 5: width of the timeout counter. Must hold `TIMEOUT_CYCLES`.

Ports:
- `clock` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `d1_in` in 32: ALU result, used as the memory address.
- `d2_in` in 32: store data.
- `rd_in` in 5: destination register.
- `memctrl_in` in 3: bit0 = read, bit1 = write, bit2 = byte access (0 = word).
- `result_out` out 32: registered stage result to MEM/WB.
- `rd_out` out 5: registered destination register.
- `stall` out 1: combinational. Holds the upstream pipeline registers and PC.
- `access_err` out 1: registered one-cycle pulse for misaligned/illegal access or bus timeout.
- `mem_req` out 1: bus request. Equals `state==WAIT`.
- `mem_we` out 1: write strobe. Valid with `mem_req`.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: write data.
- `mem_ack` in 1: transaction complete, sampled in WAIT.
- `mem_rdata` in 32: read data. Valid in the `mem_ack` cycle.

## Operation
- States: IDLE, WAIT.
- IDLE, no access (`memctrl_in[1:0]==0`):
  - `result_out<=d1_in`, `rd_out<=rd_in`.
  - `stall=0`.
- IDLE, illegal access:
  - Illegal means both read and write set, or a word access with `d1_in[1:0]!=0`.
  - No bus transaction. `result_out<=0`, `rd_out<=0`, `access_err<=1`, `stall=0`.
- IDLE, legal access:
  - `stall=1` combinationally.
  - Latch address, write data, `mem_be`, `mem_we`, `rd_in`, size, and lane.
  - Clear the timeout counter. Go to WAIT.
- Byte enables: word access = `4'b1111`. Byte access = `1<<addr[1:0]`.
- Store data: word = `d2_in`. Byte = `{4{d2_in[7:0]}}`.
- WAIT:
  - `mem_req=1`. Address, data, `be`, and `we` are stable from the latches.
  - `stall=1` unless `mem_ack`.
- WAIT with `mem_ack`:
  - `stall=0`. Go to IDLE.
  - Load result: word = `mem_rdata`. Byte = sign-extended lane `mem_rdata[8*lane+7:8*lane]` (little-endian).
  - Store: `result_out<=0`, `rd_out<=0` (no writeback).
- WAIT without `mem_ack`:
  - Counter increments.
  - When the counter reaches `TIMEOUT_CYCLES`: `stall=0`, go to IDLE, `access_err<=1`, `result_out<=0`, `rd_out<=0`.
- `mem_ack` in IDLE is ignored.
- Reset (any time, including mid-WAIT):
  - State goes to IDLE. `mem_req` drops immediately.
  - All registered outputs and latches clear to 0. `stall=0` (IDLE with reset asserted).

## Timing
- Pass-through latency: 1 cycle.
- Load/store occupancy: 1 IDLE cycle plus N WAIT cycles, where N is the cycle in which ack arrives (N≥1). `stall` is high for exactly N cycles.
- Minimum occupancy is 2 cycles, with `stall` high for 1 cycle.
- Upstream inputs must stay constant while `stall=1`.
- Result and `rd_out` update on the edge ending the ack cycle.
- `mem_req` stays high until and including the ack cycle. It is never high two transactions back-to-back without an intervening IDLE cycle.
- Timeout: `stall` is high for `TIMEOUT_CYCLES` cycles.
  - Release happens in WAIT cycle number `TIMEOUT_CYCLES`.
  - Ack in that same cycle wins: it is a normal completion and no error is raised.
- `access_err` is high for one cycle after the offending edge.

## Structure
- `mips_pkg` holds:
  - The `memctrl` bit-position constants (`MEM_RD=0`, `MEM_WR=1`, `MEM_BYTE=2`).
  - The state typedef (IDLE, WAIT).
- Sub-module `mem_lane_align`: combinational. Produces byte enables and replicated write data from size/addr, and extracts and sign-extends the load lane.

## Test plan
- Pass-through: `memctrl=0`, `d1=32'h1234`, `rd=5` → next cycle `result_out=32'h1234`, `rd_out=5`, `stall` never high.
- Word load:
  - Stimulus: addr `32'h100`, ack on the 3rd WAIT cycle with `rdata=32'hDEADBEEF`.
  - Response: `mem_addr=32'h100`, `mem_be=4'hF`, `stall` high 3 cycles, `result_out=32'hDEADBEEF`.
- Byte store then byte load:
  - Store: `d1=32'h203`, `d2=32'hAB`, `memctrl=3'b110` → `mem_be=4'b1000`, `mem_wdata=32'hABABABAB`, `mem_we=1`.
  - Load: `rdata=32'h80000000` → `result_out=32'hFFFFFF80`.
- Illegal access:
  - Misaligned word read at `32'h102` → no `mem_req`, `access_err` pulse, `rd_out=0`.
  - `memctrl=3'b011` → same response.
- Timeout: `TIMEOUT_CYCLES=4`, no ack → `stall` high 4 cycles, `access_err` pulse, `result_out=0`. Repeat with ack in the 4th cycle → no error.
- Reset mid-WAIT: drop `reset` in the 2nd WAIT cycle → `mem_req` and `stall` fall immediately, all outputs 0. A subsequent load completes normally.
